// File: rtl/mul_unit_pkg.sv
// Shared types for the RV32M multiply unit: operand bundle, op encodings and
// the operand-extension rules that distinguish MUL/MULH/MULHSU/MULHU.
package mul_unit_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] MUL_OP    = 2'b00;
  localparam logic [1:0] MULH_OP   = 2'b01;
  localparam logic [1:0] MULHSU_OP = 2'b10;
  localparam logic [1:0] MULHU_OP  = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [1:0]      op;
  } mul_inputs_t;

  function automatic logic rs1_signed(input logic [1:0] op);
    return op != MULHU_OP;
  endfunction

  function automatic logic rs2_signed(input logic [1:0] op);
    return ~op[1];
  endfunction
endpackage

// File: rtl/mul_unit_ifs.sv
// Issue-side and writeback-side handshake interfaces used by functional units.
interface func_unit_ex_interface;
  logic new_request_dec;
  logic ready;
  modport unit  (input new_request_dec, output ready);
  modport issue (output new_request_dec, input ready);
endinterface

interface unit_writeback_interface;
  logic        done_next_cycle;
  logic [31:0] rd;
  logic        accepted;
  modport unit (output done_next_cycle, output rd, input accepted);
  modport wb   (input done_next_cycle, input rd, output accepted);
endinterface

// File: rtl/mul_unit_result_fifo.sv
// In-order result buffer with a registered head entry; pops while empty are ignored.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next, remaining;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             do_pop;

  assign do_pop      = pop & (count_reg != '0);
  assign rd_ptr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
  assign remaining   = do_pop ? count_reg - 1'b1 : count_reg;

  always_comb begin
    count_next = remaining;
    if (push)
      count_next = remaining + 1'b1;
  end

  // The new head is either already in memory or is the entry being written now.
  always_comb begin
    head_next = head_reg;
    if (remaining != '0)
      head_next = mem[rd_ptr_next];
    else if (push)
      head_next = push_data;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign head  = head_reg;
  assign count = count_reg;
endmodule

// File: rtl/mul_unit.sv
// RV32M multiply unit: two-stage multiply pipeline feeding an in-order result
// FIFO; admission is throttled so buffered plus in-flight results never exceed the FIFO.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  mul_inputs_t             mul_inputs,
  func_unit_ex_interface.unit     mul_ex,
  unit_writeback_interface.unit   mul_wb
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            s1_valid_reg, s2_valid_reg;
  logic [XLEN:0]   s1_rs1_reg, s1_rs2_reg;
  logic [1:0]      s1_op_reg, s2_op_reg;
  logic [63:0]     s2_product_reg;
  logic [63:0]     rs1_wide, rs2_wide;
  logic [XLEN-1:0] result;
  logic [CW-1:0]   count;
  logic [CW:0]     in_use;
  logic            accept;

  assign in_use = {1'b0, count} + {{CW{1'b0}}, s1_valid_reg} + {{CW{1'b0}}, s2_valid_reg};
  assign mul_ex.ready = in_use < (CW+1)'(FIFO_DEPTH);
  assign accept = mul_ex.new_request_dec & mul_ex.ready;

  // Only the low 64 bits of the 66-bit signed product are ever selected,
  // so extending the 33-bit operands to 64 bits and multiplying modulo 2^64 suffices.
  assign rs1_wide = {{(63-XLEN){s1_rs1_reg[XLEN]}}, s1_rs1_reg};
  assign rs2_wide = {{(63-XLEN){s1_rs2_reg[XLEN]}}, s1_rs2_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_rs1_reg <= {rs1_signed(mul_inputs.op) & mul_inputs.rs1[XLEN-1], mul_inputs.rs1};
      s1_rs2_reg <= {rs2_signed(mul_inputs.op) & mul_inputs.rs2[XLEN-1], mul_inputs.rs2};
      s1_op_reg  <= mul_inputs.op;
    end
    s2_product_reg <= rs1_wide * rs2_wide;
    s2_op_reg      <= s1_op_reg;
  end

  assign result = (s2_op_reg == MUL_OP) ? s2_product_reg[XLEN-1:0] : s2_product_reg[2*XLEN-1:XLEN];

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_valid_reg),
    .push_data (result),
    .pop       (mul_wb.accepted),
    .head      (mul_wb.rd),
    .count     (count)
  );

  // Drops during the accept of the last entry so it is never offered twice.
  assign mul_wb.done_next_cycle = (count >= CW'(2)) | ((count == CW'(1)) & ~mul_wb.accepted);
endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vector table, backpressure,
// last-entry accept, mid-stream reset and randomized traffic against a scoreboard.
module tb_mul_unit;
  import mul_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  mul_inputs_t mul_inputs;

  func_unit_ex_interface   mul_ex();
  unit_writeback_interface mul_wb();

  mul_unit #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mul_inputs (mul_inputs),
    .mul_ex     (mul_ex),
    .mul_wb     (mul_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] sb [$];
  int          tests = 0;
  int          fails = 0;
  bit          auto_acc = 1'b0;
  bit          manual_acc = 1'b0;
  bit          rand_delay = 1'b0;
  int          acc_wait = 0;

  // Reference built from an unsigned 64-bit product with signed corrections.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [63:0] u;
    logic [31:0] hi;
    u  = {32'h0, a} * {32'h0, b};
    hi = u[63:32];
    case (op)
      2'b00:   return u[31:0];
      2'b01:   return hi - (a[31] ? b : 32'h0) - (b[31] ? a : 32'h0);
      2'b10:   return hi - (a[31] ? b : 32'h0);
      default: return hi;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    while (!mul_ex.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!mul_ex.ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: ready=0 after 200 cycles, expected 1");
    end else begin
      mul_inputs = '{rs1: a, rs2: b, op: op};
      mul_ex.new_request_dec = 1'b1;
      @(posedge clk);
      sb.push_back(exp);
      #1;
      mul_ex.new_request_dec = 1'b0;
      mul_inputs = '{rs1: $urandom, rs2: $urandom, op: 2'b00};
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Writeback side: sample with accepted low, then accept and score the head.
  initial begin
    mul_wb.accepted = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_acc) begin
        mul_wb.accepted = 1'b0;
        #1;
        if (mul_wb.done_next_cycle) begin
          if (acc_wait > 0) begin
            acc_wait--;
          end else begin
            if (sb.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_result: got 0x%08h, expected no result", mul_wb.rd);
            end else begin
              check("result", mul_wb.rd, sb.pop_front());
            end
            mul_wb.accepted = 1'b1;
            acc_wait = rand_delay ? int'($urandom_range(0, 15)) : 0;
          end
        end
      end else begin
        mul_wb.accepted = manual_acc;
      end
    end
  end

  initial begin
    logic [31:0] a, b, e, first;
    logic [1:0]  op;
    int          n;

    vecs[0]  = '{32'h00007e00, 32'hb6db6db7, MUL_OP,    32'h00001200};
    vecs[1]  = '{32'hffffffff, 32'hffffffff, MUL_OP,    32'h00000001};
    vecs[2]  = '{32'h00000003, 32'h00000007, MUL_OP,    32'h00000015};
    vecs[3]  = '{32'haaaaaaab, 32'h0002fe7d, MULH_OP,   32'hffff0081};
    vecs[4]  = '{32'hff000000, 32'hff000000, MULH_OP,   32'h00010000};
    vecs[5]  = '{32'hffffffff, 32'h00000001, MULH_OP,   32'hffffffff};
    vecs[6]  = '{32'h80000000, 32'hffff8000, MULHSU_OP, 32'h80004000};
    vecs[7]  = '{32'h0002fe7d, 32'haaaaaaab, MULHSU_OP, 32'h0001fefe};
    vecs[8]  = '{32'h00000001, 32'hffffffff, MULHSU_OP, 32'h00000000};
    vecs[9]  = '{32'hff000000, 32'hff000000, MULHU_OP,  32'hfe010000};
    vecs[10] = '{32'hffffffff, 32'hffffffff, MULHU_OP,  32'hfffffffe};
    vecs[11] = '{32'h80000000, 32'hffff8000, MULHU_OP,  32'h7fffc000};

    rst = 1'b1;
    mul_ex.new_request_dec = 1'b0;
    mul_inputs = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, mul_ex.ready}, 32'd1);
    check("reset_done", {31'b0, mul_wb.done_next_cycle}, 32'd0);
    check("reset_rd", mul_wb.rd, 32'd0);

    // Directed vectors, back-to-back with immediate acceptance.
    auto_acc = 1'b1;
    for (int i = 0; i < 12; i++)
      issue(vecs[i].rs1, vecs[i].rs2, vecs[i].op, vecs[i].exp);
    drain(200);
    check("idle_after_table", {31'b0, mul_wb.done_next_cycle}, 32'd0);

    // Single entry: done must drop in the cycle it is accepted.
    auto_acc = 1'b0;
    manual_acc = 1'b0;
    issue(32'd3, 32'd7, MUL_OP, 32'h15);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!mul_wb.done_next_cycle && n < 20);
    check("single_done", {31'b0, mul_wb.done_next_cycle}, 32'd1);
    check("single_rd", mul_wb.rd, sb.pop_front());
    manual_acc = 1'b1;
    @(negedge clk);
    #2;
    check("done_drop_on_accept", {31'b0, mul_wb.done_next_cycle}, 32'd0);
    manual_acc = 1'b0;
    @(negedge clk);
    #2;
    check("done_after_pop", {31'b0, mul_wb.done_next_cycle}, 32'd0);
    check("ready_after_pop", {31'b0, mul_ex.ready}, 32'd1);

    // Backpressure: ready falls after FIFO_DEPTH accepts, head holds.
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i*3+1].rs1, vecs[i*3+1].rs2, vecs[i*3+1].op, vecs[i*3+1].exp);
      check($sformatf("bp_ready_%0d", i), {31'b0, mul_ex.ready}, (i < 3) ? 32'd1 : 32'd0);
    end
    first = sb[0];
    repeat (20) begin
      @(negedge clk);
      #2;
      check("bp_rd_hold", mul_wb.rd, first);
    end
    check("bp_done", {31'b0, mul_wb.done_next_cycle}, 32'd1);
    check("bp_ready_held", {31'b0, mul_ex.ready}, 32'd0);
    auto_acc = 1'b1;
    drain(200);
    check("idle_after_bp", {31'b0, mul_wb.done_next_cycle}, 32'd0);

    // Reset with three requests in flight.
    auto_acc = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(vecs[i+9].rs1, vecs[i+9].rs2, vecs[i+9].op, vecs[i+9].exp);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_mid_done", {31'b0, mul_wb.done_next_cycle}, 32'd0);
    check("rst_mid_ready", {31'b0, mul_ex.ready}, 32'd1);
    check("rst_mid_rd", mul_wb.rd, 32'd0);
    repeat (8) begin
      @(negedge clk);
      #2;
      check("rst_no_stale", {31'b0, mul_wb.done_next_cycle}, 32'd0);
    end
    auto_acc = 1'b1;
    issue(vecs[4].rs1, vecs[4].rs2, vecs[4].op, vecs[4].exp);
    drain(100);

    // Random traffic with random writeback delays.
    rand_delay = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'hffffffff;
      if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 1) ? 32'h7fffffff : 32'h00000000;
      e  = model(a, b, op);
      issue(a, b, op, e);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain(20000);
    check("idle_after_random", {31'b0, mul_wb.done_next_cycle}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
